// File: rtl/key_display_ctrl.sv
`timescale 1ns/1ps
// key_display_ctrl: sequences what the HEX digits show during an RC4 key search.
// Shows a rate-limited live key while searching, holds the key once found,
// and blinks all digits as F when the search fails.
//
// Ports:
//   clk        - system clock, rising edge
//   reset_n    - synchronous active-low reset
//   start      - pulse, begin a new search display
//   key_in     - current candidate key, digit i = key_in[4i+3:4i]
//   key_valid  - key_in holds a new candidate this cycle
//   found      - pulse, key_in is the correct key
//   fail       - pulse, key space exhausted
//   nibble_out - per-digit nibble to the seven-segment decoders
//   blank_out  - per-digit blank flag, 1 = digit off
//   state_out  - 00 IDLE, 01 SEARCH, 10 FOUND, 11 FAIL
module key_display_ctrl #(
    parameter int DIGITS         = 6,
    parameter int REFRESH_CYCLES = 2500000,
    parameter int BLINK_CYCLES   = 25000000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [4*DIGITS-1:0] key_in,
    input  logic                key_valid,
    input  logic                found,
    input  logic                fail,
    output logic [4*DIGITS-1:0] nibble_out,
    output logic [DIGITS-1:0]   blank_out,
    output logic [1:0]          state_out
);

    localparam int KW = 4 * DIGITS;
    localparam int RW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

    localparam logic [RW-1:0] REF_LAST   = RW'(REFRESH_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SEARCH = 2'b01,
        FOUND  = 2'b10,
        FAIL   = 2'b11
    } stateE;

    stateE           stateQ, stateD;
    logic [KW-1:0]   nibbleQ, nibbleD;
    logic [DIGITS-1:0] blankQ, blankD;
    logic [KW-1:0]   shadowQ, shadowD;
    logic [RW-1:0]   refCntQ, refCntD;
    logic [BW-1:0]   blinkCntQ, blinkCntD;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stateQ    <= IDLE;
            nibbleQ   <= '0;
            blankQ    <= '1;
            shadowQ   <= '0;
            refCntQ   <= '0;
            blinkCntQ <= '0;
        end else begin
            stateQ    <= stateD;
            nibbleQ   <= nibbleD;
            blankQ    <= blankD;
            shadowQ   <= shadowD;
            refCntQ   <= refCntD;
            blinkCntQ <= blinkCntD;
        end
    end

    always_comb begin
        stateD    = stateQ;
        nibbleD   = nibbleQ;
        blankD    = blankQ;
        shadowD   = shadowQ;
        refCntD   = refCntQ;
        blinkCntD = blinkCntQ;

        if (start) begin
            stateD    = SEARCH;
            nibbleD   = '0;
            blankD    = '0;
            shadowD   = key_valid ? key_in : '0;
            refCntD   = '0;
            blinkCntD = '0;
        end else begin
            unique case (stateQ)
                SEARCH: begin
                    if (found) begin
                        stateD  = FOUND;
                        nibbleD = key_in;
                    end else if (fail) begin
                        stateD    = FAIL;
                        nibbleD   = '1;
                        blankD    = '0;
                        blinkCntD = '0;
                    end else begin
                        if (key_valid) begin
                            shadowD = key_in;
                        end
                        // Display takes the pre-update shadow, so a key
                        // arriving on a refresh cycle waits for the next one.
                        if (refCntQ == REF_LAST) begin
                            nibbleD = shadowQ;
                            refCntD = '0;
                        end else begin
                            refCntD = refCntQ + RW'(1);
                        end
                    end
                end
                FAIL: begin
                    if (blinkCntQ == BLINK_LAST) begin
                        blankD    = ~blankQ;
                        blinkCntD = '0;
                    end else begin
                        blinkCntD = blinkCntQ + BW'(1);
                    end
                end
                IDLE, FOUND: begin
                end
                default: begin
                end
            endcase
        end
    end

    assign nibble_out = nibbleQ;
    assign blank_out  = blankQ;
    assign state_out  = stateQ;

endmodule
